// File: rtl/uarc_console_ctrl.sv
// Console bus controller: core send/receive handshakes bridged to TX/RX byte FIFOs.
// Optional RX-to-TX echo is enabled by defining CONSOLE_ECHO_EN.
module uarc_console_ctrl #(
  parameter int WORD_WIDTH     = 32,
  parameter int FIFO_DEPTH_MAG = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      core_send,
  input  logic [WORD_WIDTH-1:0]     core_data,
  output logic                      core_send_ack,
  output logic                      core_recv_valid,
  output logic [WORD_WIDTH-1:0]     core_recv_data,
  input  logic                      core_recv_ack,
  output logic                      tx_valid,
  output logic [7:0]                tx_data,
  input  logic                      tx_ready,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      rx_ready,
  output logic [FIFO_DEPTH_MAG:0]   tx_count,
  output logic [FIFO_DEPTH_MAG:0]   rx_count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_MAG;
  localparam logic [FIFO_DEPTH_MAG:0]   FULL_COUNT = (FIFO_DEPTH_MAG+1)'(DEPTH);
  localparam logic [FIFO_DEPTH_MAG:0]   CNT_ONE    = (FIFO_DEPTH_MAG+1)'(1);
  localparam logic [FIFO_DEPTH_MAG-1:0] PTR_ONE    = FIFO_DEPTH_MAG'(1);

  typedef enum logic {IDLE, ACK} send_state_t;

  send_state_t state, state_next;

  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];
  logic [FIFO_DEPTH_MAG-1:0] tx_rd_ptr, tx_wr_ptr, rx_rd_ptr, rx_wr_ptr;

  logic tx_full, core_push, echo_push, tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0] tx_push_data;
  logic core_data_unused;

  assign core_data_unused = ^core_data[WORD_WIDTH-1:8];

  assign tx_full         = (tx_count == FULL_COUNT);
  assign tx_valid        = (tx_count != '0);
  assign tx_data         = tx_mem[tx_rd_ptr];
  assign core_recv_valid = (rx_count != '0);
  assign core_recv_data  = {{(WORD_WIDTH-8){1'b0}}, rx_mem[rx_rd_ptr]};
  assign core_send_ack   = (state == ACK);

`ifdef CONSOLE_ECHO_EN
  // Echo needs a TX slot too, so RX acceptance waits for TX space.
  assign rx_ready  = (rx_count != FULL_COUNT) && !tx_full;
  assign echo_push = rx_valid && rx_ready;
`else
  assign rx_ready  = (rx_count != FULL_COUNT);
  assign echo_push = 1'b0;
`endif

  assign tx_push      = core_push || echo_push;
  assign tx_push_data = echo_push ? rx_data : core_data[7:0];
  assign tx_pop       = tx_valid && tx_ready;
  assign rx_push      = rx_valid && rx_ready;
  assign rx_pop       = core_recv_valid && core_recv_ack;

  // ACK ignores core_send so a request held through its ack is pushed once.
  always_comb begin
    state_next = state;
    core_push  = 1'b0;
    case (state)
      IDLE: begin
        if (core_send && !tx_full && !echo_push) begin
          core_push  = 1'b1;
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      tx_count  <= '0;
      rx_count  <= '0;
    end else begin
      state <= state_next;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      if (tx_push && !tx_pop)      tx_count <= tx_count + CNT_ONE;
      else if (!tx_push && tx_pop) tx_count <= tx_count - CNT_ONE;
      if (rx_push && !rx_pop)      rx_count <= rx_count + CNT_ONE;
      else if (!rx_push && rx_pop) rx_count <= rx_count - CNT_ONE;
    end
  end

  // Storage needs no reset; the counts decide which entries are live.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_push_data;
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

endmodule

// File: tb/tb_uarc_console_ctrl.sv
// Self-checking bench for uarc_console_ctrl: vector table plus directed multi-cycle sequences.
module tb_uarc_console_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_send;
  logic [31:0] core_data;
  logic        core_send_ack;
  logic        core_recv_valid;
  logic [31:0] core_recv_data;
  logic        core_recv_ack;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [3:0]  tx_count;
  logic [3:0]  rx_count;

  int checks = 0;
  int errors = 0;

  uarc_console_ctrl #(.WORD_WIDTH(32), .FIFO_DEPTH_MAG(3)) dut (
    .clk(clk), .reset(reset),
    .core_send(core_send), .core_data(core_data), .core_send_ack(core_send_ack),
    .core_recv_valid(core_recv_valid), .core_recv_data(core_recv_data),
    .core_recv_ack(core_recv_ack),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        send;
    logic [31:0] data;
    logic        recv_ack;
    logic        txr;
    logic        rxv;
    logic [7:0]  rxd;
    logic        e_ack;
    logic [3:0]  e_tx_count;
    logic [7:0]  e_tx_data;
    logic [3:0]  e_rx_count;
    logic [7:0]  e_recv_data;
    logic        e_rx_ready;
  } vec_t;

  vec_t vecs [15];
  logic [7:0] rx_model [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic send, input logic [31:0] data, input logic rack,
                               input logic txr, input logic rxv, input logic [7:0] rxd);
    core_send     = send;
    core_data     = data;
    core_recv_ack = rack;
    tx_ready      = txr;
    rx_valid      = rxv;
    rx_data       = rxd;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset(input string tag);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput({tag, " rst tx_valid"}, {31'b0, tx_valid}, 32'd0);
    checkOutput({tag, " rst tx_count"}, {28'b0, tx_count}, 32'd0);
    checkOutput({tag, " rst rx_count"}, {28'b0, rx_count}, 32'd0);
    checkOutput({tag, " rst ack"}, {31'b0, core_send_ack}, 32'd0);
    checkOutput({tag, " rst recv_valid"}, {31'b0, core_recv_valid}, 32'd0);
    checkOutput({tag, " rst rx_ready"}, {31'b0, rx_ready}, 32'd1);
    reset = 1'b0;
  endtask

  // Hold core_send with a new word until an ack shows up or the bound expires.
  task automatic sendByte(input logic [31:0] d, input int bound, output bit got);
    got = 1'b0;
    core_send = 1'b1;
    core_data = d;
    for (int c = 0; c < bound; c++) begin
      tick();
      if (core_send_ack) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic rxCycle(input logic v, input logic [7:0] d, input logic a);
    bit exp_ready, pop;
    exp_ready = (rx_model.size() != 8);
    pop = a && (rx_model.size() != 0);
    checkOutput("rx_ready pre", {31'b0, rx_ready}, {31'b0, exp_ready});
    applyStimulus(1'b0, 32'h0, a, 1'b1, v, d);
    tick();
    if (pop) void'(rx_model.pop_front());
    if (v && exp_ready) rx_model.push_back(d);
    checkOutput("rx_count", {28'b0, rx_count}, rx_model.size());
    if (rx_model.size() != 0)
      checkOutput("rx head", core_recv_data, {24'b0, rx_model[0]});
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit got;
    int acks;

    vecs[0]  = '{1'b1, 32'h48,       1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 4'd1, 8'h48, 4'd0, 8'h00, 1'b1};
    vecs[1]  = '{1'b1, 32'h48,       1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd0, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h48, 1'b0, 4'd0, 8'h00, 4'd1, 8'h48, 1'b1};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h49, 1'b0, 4'd0, 8'h00, 4'd2, 8'h48, 1'b1};
    vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h0D, 1'b0, 4'd0, 8'h00, 4'd3, 8'h48, 1'b1};
    vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd2, 8'h49, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd1, 8'h0D, 1'b1};
    vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd0, 8'h00, 1'b1};
    vecs[8]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd0, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 4'd0, 8'h00, 4'd1, 8'h55, 1'b1};
    vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h66, 1'b0, 4'd0, 8'h00, 4'd1, 8'h66, 1'b1};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd0, 8'h00, 1'b1};
    vecs[12] = '{1'b1, 32'hFFFFFF5A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd1, 8'h5A, 4'd0, 8'h00, 1'b1};
    vecs[13] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 8'h5A, 4'd0, 8'h00, 1'b1};
    vecs[14] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd0, 8'h00, 1'b1};

    doReset("init");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].send, vecs[i].data, vecs[i].recv_ack, vecs[i].txr, vecs[i].rxv, vecs[i].rxd);
      tick();
      checkOutput($sformatf("v%0d ack", i), {31'b0, core_send_ack}, {31'b0, vecs[i].e_ack});
      checkOutput($sformatf("v%0d tx_count", i), {28'b0, tx_count}, {28'b0, vecs[i].e_tx_count});
      checkOutput($sformatf("v%0d tx_valid", i), {31'b0, tx_valid}, {31'b0, (vecs[i].e_tx_count != 0)});
      if (vecs[i].e_tx_count != 0)
        checkOutput($sformatf("v%0d tx_data", i), {24'b0, tx_data}, {24'b0, vecs[i].e_tx_data});
      checkOutput($sformatf("v%0d rx_count", i), {28'b0, rx_count}, {28'b0, vecs[i].e_rx_count});
      checkOutput($sformatf("v%0d recv_valid", i), {31'b0, core_recv_valid}, {31'b0, (vecs[i].e_rx_count != 0)});
      if (vecs[i].e_rx_count != 0)
        checkOutput($sformatf("v%0d recv_data", i), core_recv_data, {24'b0, vecs[i].e_recv_data});
      checkOutput($sformatf("v%0d rx_ready", i), {31'b0, rx_ready}, {31'b0, vecs[i].e_rx_ready});
    end

    // TX fill: eight sends acked, ninth stalls until a single pop frees a slot.
    doReset("txfull");
    acks = 0;
    for (int i = 0; i < 9; i++) begin
      sendByte(32'h30 + i, (i < 8) ? 4 : 6, got);
      if (got) acks++;
    end
    checkOutput("fill acks", acks, 32'd8);
    checkOutput("fill tx_count", {28'b0, tx_count}, 32'd8);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    checkOutput("pop edge ack", {31'b0, core_send_ack}, 32'd0);
    got = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (!got) begin
        tick();
        if (core_send_ack) got = 1'b1;
      end
    end
    checkOutput("ninth ack", {31'b0, got}, 32'd1);
    checkOutput("refill tx_count", {28'b0, tx_count}, 32'd8);
    core_send = 1'b0;
    tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("drain %0d", k), {24'b0, tx_data}, 32'h31 + k);
      tick();
    end
    tx_ready = 1'b0;
    checkOutput("drained tx_valid", {31'b0, tx_valid}, 32'd0);

    // RX fill, reject while full, then simultaneous push/pop across the wrap.
    doReset("rxwrap");
    rx_model.delete();
    for (int i = 0; i < 8; i++) rxCycle(1'b1, 8'hA0 + 8'(i), 1'b0);
    rxCycle(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) rxCycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rxCycle(1'b1, 8'hA8 + 8'(i), 1'b1);
      checkOutput("steady rx_count", {28'b0, rx_count}, 32'd4);
    end
    for (int i = 0; i < 4; i++) rxCycle(1'b0, 8'h00, 1'b1);
    checkOutput("rx empty", {31'b0, core_recv_valid}, 32'd0);

    // RX byte and core send colliding in one cycle.
    doReset("collide");
    applyStimulus(1'b1, 32'h42, 1'b0, 1'b0, 1'b1, 8'h41);
    tick();
    rx_valid = 1'b0;
`ifdef CONSOLE_ECHO_EN
    checkOutput("echo ack1", {31'b0, core_send_ack}, 32'd0);
    checkOutput("echo txc1", {28'b0, tx_count}, 32'd1);
    checkOutput("echo head1", {24'b0, tx_data}, 32'h41);
    tick();
    core_send = 1'b0;
    checkOutput("echo ack2", {31'b0, core_send_ack}, 32'd1);
    checkOutput("echo txc2", {28'b0, tx_count}, 32'd2);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    checkOutput("echo head2", {24'b0, tx_data}, 32'h42);
`else
    core_send = 1'b0;
    checkOutput("noecho ack1", {31'b0, core_send_ack}, 32'd1);
    checkOutput("noecho txc1", {28'b0, tx_count}, 32'd1);
    checkOutput("noecho head1", {24'b0, tx_data}, 32'h42);
    tick();
    checkOutput("noecho ack2", {31'b0, core_send_ack}, 32'd0);
    checkOutput("noecho txc2", {28'b0, tx_count}, 32'd1);
`endif
    checkOutput("collide rx_count", {28'b0, rx_count}, 32'd1);
    checkOutput("collide rx head", core_recv_data, 32'h41);

    // Reset mid-stream during an ack pulse with five bytes queued.
    doReset("midrst");
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      sendByte(32'h60 + i, 4, got);
      if (got) acks++;
    end
    checkOutput("pre-rst acks", acks, 32'd5);
    checkOutput("pre-rst tx_count", {28'b0, tx_count}, 32'd5);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid-rst tx_valid", {31'b0, tx_valid}, 32'd0);
    checkOutput("mid-rst tx_count", {28'b0, tx_count}, 32'd0);
    checkOutput("mid-rst ack", {31'b0, core_send_ack}, 32'd0);
    checkOutput("mid-rst rx_ready", {31'b0, rx_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    checkOutput("post-rst ack", {31'b0, core_send_ack}, 32'd1);
    checkOutput("post-rst tx_count", {28'b0, tx_count}, 32'd1);
    checkOutput("post-rst tx_data", {24'b0, tx_data}, 32'h64);
    core_send = 1'b0;
    tick();
    checkOutput("post-rst ack drop", {31'b0, core_send_ack}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
